// File: rtl/galaga_shot_arbiter_if.sv
// Shot-lane bundle between the ship side and the shot arbiter.
// master = ship/player side, slave = arbiter.
interface galaga_shot_arbiter_if #(
  parameter int ROW_W   = 3,
  parameter int SCORE_W = 2
);
  logic               dp1;
  logic               dp2;
  logic               p1a;
  logic               p1b;
  logic               p1c;
  logic               p2a;
  logic               p2b;
  logic               p2c;
  logic               gnt1;
  logic               gnt2;
  logic               busy;
  logic               shot_owner;
  logic [2:0]         shot_col;
  logic [ROW_W-1:0]   shot_row;
  logic               hit1;
  logic               hit2;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               done;
  logic               winner;

  modport master (
    output dp1, dp2,
    output p1a, p1b, p1c,
    output p2a, p2b, p2c,
    input  gnt1, gnt2, busy,
    input  shot_owner, shot_col, shot_row,
    input  hit1, hit2,
    input  score1, score2,
    input  done, winner
  );

  modport slave (
    input  dp1, dp2,
    input  p1a, p1b, p1c,
    input  p2a, p2b, p2c,
    output gnt1, gnt2, busy,
    output shot_owner, shot_col, shot_row,
    output hit1, hit2,
    output score1, score2,
    output done, winner
  );
endinterface

// File: rtl/galaga_shot_arbiter.sv
// Shared shot-lane arbiter: grant, flight, hit/score, game over.
// Define SHOT_QUEUE_EN to remember presses that arrive while busy.
module galaga_shot_arbiter #(
  parameter int TRAVEL    = 4,
  parameter int STEP_DIV  = 1,
  parameter int COOLDOWN  = 2,
  parameter int WIN_SCORE = 3,
  parameter int ROW_W     = 3,
  parameter int SCORE_W   = 2
) (
  input logic                 clk,
  input logic                 rst,
  galaga_shot_arbiter_if.slave bus
);

  localparam int CW =
    (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int SW =
    (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, LAUNCH, FLY, RESOLVE, OVER
  } state_t;

  state_t             state, state_d;
  logic               dp1_q, dp2_q;
  logic [CW-1:0]      cd, cd_d;
  logic [SW-1:0]      step, step_d;
  logic [ROW_W-1:0]   row, row_d;
  logic               prio, prio_d;
  logic               gnt1, gnt1_d;
  logic               gnt2, gnt2_d;
  logic               busy, busy_d;
  logic               owner, owner_d;
  logic [2:0]         col, col_d;
  logic               hit1, hit1_d;
  logic               hit2, hit2_d;
  logic [SCORE_W-1:0] sc1, sc1_d;
  logic [SCORE_W-1:0] sc2, sc2_d;
  logic               done, done_d;
  logic               win, win_d;

  logic               press1, press2;
  logic               req1, req2;
  logic               el1, el2;
  logic               g1, g2;
  logic               open;
  logic               hit, fin;
  logic [2:0]         pos1, pos2, opp;
  logic [SCORE_W-1:0] nsc;

  function automatic logic onehot3(
    input logic [2:0] v
  );
    return (v == 3'b100) || (v == 3'b010) ||
           (v == 3'b001);
  endfunction

  assign pos1   = {bus.p1a, bus.p1b, bus.p1c};
  assign pos2   = {bus.p2a, bus.p2b, bus.p2c};
  assign press1 = bus.dp1 & ~dp1_q;
  assign press2 = bus.dp2 & ~dp2_q;

`ifdef SHOT_QUEUE_EN
  logic pend1, pend2;

  assign req1 = press1 | pend1;
  assign req2 = press2 | pend2;

  // Flags live across busy/cooldown; wiped when the game ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend1 <= 1'b0;
      pend2 <= 1'b0;
    end else if (state == OVER ||
                 state_d == OVER) begin
      pend1 <= 1'b0;
      pend2 <= 1'b0;
    end else begin
      pend1 <= (pend1 | press1) & ~g1;
      pend2 <= (pend2 | press2) & ~g2;
    end
  end
`else
  assign req1 = press1;
  assign req2 = press2;
`endif

  assign el1  = req1 & onehot3(pos1);
  assign el2  = req2 & onehot3(pos2);
  assign open = (state == IDLE) && (cd == '0);
  // prio=1 means P1 won last, so P2 takes the tie.
  assign g1   = open && el1 && (!el2 || !prio);
  assign g2   = open && el2 && !g1;

  assign opp  = owner ? pos1 : pos2;
  assign hit  = (col == opp);
  assign nsc  = (owner ? sc2 : sc1) +
                SCORE_W'(1);
  assign fin  = hit &&
                (nsc == SCORE_W'(WIN_SCORE));

  always_comb begin
    state_d = state;
    cd_d    = cd;
    step_d  = step;
    row_d   = row;
    prio_d  = prio;
    gnt1_d  = 1'b0;
    gnt2_d  = 1'b0;
    busy_d  = busy;
    owner_d = owner;
    col_d   = col;
    hit1_d  = 1'b0;
    hit2_d  = 1'b0;
    sc1_d   = sc1;
    sc2_d   = sc2;
    done_d  = done;
    win_d   = win;
    unique case (state)
      IDLE: begin
        if (cd != '0) begin
          cd_d = cd - CW'(1);
        end else if (g1 || g2) begin
          state_d = LAUNCH;
          gnt1_d  = g1;
          gnt2_d  = g2;
          busy_d  = 1'b1;
          owner_d = g2;
          col_d   = g2 ? pos2 : pos1;
          prio_d  = g1;
        end
      end
      LAUNCH: begin
        state_d = FLY;
        row_d   = '0;
        step_d  = '0;
      end
      FLY: begin
        if (step == SW'(STEP_DIV - 1)) begin
          step_d = '0;
          if (row == ROW_W'(TRAVEL - 1)) begin
            state_d = RESOLVE;
            row_d   = '0;
          end else begin
            row_d = row + ROW_W'(1);
          end
        end else begin
          step_d = step + SW'(1);
        end
      end
      RESOLVE: begin
        busy_d  = 1'b0;
        owner_d = 1'b0;
        col_d   = '0;
        if (hit && owner) begin
          hit2_d = 1'b1;
          sc2_d  = nsc;
        end else if (hit) begin
          hit1_d = 1'b1;
          sc1_d  = nsc;
        end
        if (fin) begin
          state_d = OVER;
          done_d  = 1'b1;
          win_d   = owner;
        end else begin
          state_d = IDLE;
          cd_d    = CW'(COOLDOWN);
        end
      end
      OVER: state_d = OVER;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dp1_q <= 1'b0;
      dp2_q <= 1'b0;
      cd    <= '0;
      step  <= '0;
      row   <= '0;
      prio  <= 1'b0;
      gnt1  <= 1'b0;
      gnt2  <= 1'b0;
      busy  <= 1'b0;
      owner <= 1'b0;
      col   <= '0;
      hit1  <= 1'b0;
      hit2  <= 1'b0;
      sc1   <= '0;
      sc2   <= '0;
      done  <= 1'b0;
      win   <= 1'b0;
    end else begin
      state <= state_d;
      dp1_q <= bus.dp1;
      dp2_q <= bus.dp2;
      cd    <= cd_d;
      step  <= step_d;
      row   <= row_d;
      prio  <= prio_d;
      gnt1  <= gnt1_d;
      gnt2  <= gnt2_d;
      busy  <= busy_d;
      owner <= owner_d;
      col   <= col_d;
      hit1  <= hit1_d;
      hit2  <= hit2_d;
      sc1   <= sc1_d;
      sc2   <= sc2_d;
      done  <= done_d;
      win   <= win_d;
    end
  end

  assign bus.gnt1       = gnt1;
  assign bus.gnt2       = gnt2;
  assign bus.busy       = busy;
  assign bus.shot_owner = owner;
  assign bus.shot_col   = col;
  assign bus.shot_row   = row;
  assign bus.hit1       = hit1;
  assign bus.hit2       = hit2;
  assign bus.score1     = sc1;
  assign bus.score2     = sc2;
  assign bus.done       = done;
  assign bus.winner     = win;

endmodule

// File: tb/tb_galaga_shot_arbiter.sv
// Directed bench for galaga_shot_arbiter with a shot scoreboard.
// Covers both builds (SHOT_QUEUE_EN defined or not).
module tb_galaga_shot_arbiter;

  localparam int WIN = 3;
  localparam logic [2:0] PA = 3'b100;
  localparam logic [2:0] PB = 3'b010;
  localparam logic [2:0] PC = 3'b001;

  typedef struct {
    logic       own;
    logic [2:0] col;
    logic       hit;
    logic [1:0] s1;
    logic [1:0] s2;
  } exp_t;

  logic clk;
  logic rst;
  int   npass;
  int   ntotal;
  exp_t sb[$];

  galaga_shot_arbiter_if #(
    .ROW_W(3), .SCORE_W(2)
  ) bus ();

  galaga_shot_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic setpos(
    input logic [2:0] a,
    input logic [2:0] b
  );
    {bus.p1a, bus.p1b, bus.p1c} = a;
    {bus.p2a, bus.p2b, bus.p2c} = b;
  endtask

  task automatic press_tick(
    input logic d1,
    input logic d2
  );
    bus.dp1 = d1;
    bus.dp2 = d2;
    tick();
    bus.dp1 = 1'b0;
    bus.dp2 = 1'b0;
  endtask

  task automatic push(
    input logic       own,
    input logic [2:0] col,
    input logic       hit,
    input logic [1:0] s1,
    input logic [1:0] s2
  );
    exp_t e;
    e.own = own;
    e.col = col;
    e.hit = hit;
    e.s1  = s1;
    e.s2  = s2;
    sb.push_back(e);
  endtask

  // Waits for a grant, then follows the shot to its resolve.
  task automatic serve(
    input int         budget,
    input int         expwait,
    input logic [2:0] np1,
    input logic [2:0] np2,
    input logic       md1,
    input logic       md2
  );
    exp_t e;
    int   n;
    logic fin;
    n = 0;
    while (!(bus.gnt1 || bus.gnt2) &&
           n < budget) begin
      tick();
      n++;
    end
    chk("grant_wait", n, expwait);
    if (sb.size() == 0) begin
      chk("sb_unexpected_grant",
          {bus.gnt1, bus.gnt2}, 0);
      return;
    end
    e = sb.pop_front();
    chk("gnt1", bus.gnt1, !e.own);
    chk("gnt2", bus.gnt2, e.own);
    chk("owner", bus.shot_owner, e.own);
    chk("col", bus.shot_col, e.col);
    chk("busy_launch", bus.busy, 1);
    for (int r = 0; r < 4; r++) begin
      tick();
      if (r == 0) begin
        if (np1 != 3'b000 || np2 != 3'b000)
          setpos(
            (np1 != 3'b000) ? np1 :
              {bus.p1a, bus.p1b, bus.p1c},
            (np2 != 3'b000) ? np2 :
              {bus.p2a, bus.p2b, bus.p2c});
        bus.dp1 = md1;
        bus.dp2 = md2;
      end else begin
        bus.dp1 = 1'b0;
        bus.dp2 = 1'b0;
      end
      chk("row", bus.shot_row, r);
      chk("fly_gnt", {bus.gnt1, bus.gnt2}, 0);
    end
    tick();
    chk("resolve_row", bus.shot_row, 0);
    chk("resolve_busy", bus.busy, 1);
    tick();
    fin = ((e.own ? e.s2 : e.s1) == 2'(WIN));
    if (!fin) begin
      chk("hit1", bus.hit1, e.hit && !e.own);
      chk("hit2", bus.hit2, e.hit && e.own);
    end
    chk("score1", bus.score1, e.s1);
    chk("score2", bus.score2, e.s2);
    chk("busy_end", bus.busy, 0);
    chk("col_end", bus.shot_col, 0);
    chk("done", bus.done, fin);
    if (fin) chk("winner", bus.winner, e.own);
  endtask

  initial begin
    npass  = 0;
    ntotal = 0;
    rst    = 1'b1;
    bus.dp1 = 1'b0;
    bus.dp2 = 1'b0;
    setpos(PA, PA);
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_gnt", {bus.gnt1, bus.gnt2}, 0);
    chk("rst_scores",
        {bus.score1, bus.score2}, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_row", bus.shot_row, 0);
    rst = 1'b0;

    // Aligned P1 shot hits.
    push(0, PA, 1, 1, 0);
    press_tick(1, 0);
    serve(0, 0, 0, 0, 0, 0);

    // Cooldown blocks E+7; E+9 is granted.
    setpos(PC, PC);
    press_tick(1, 0);
    chk("cd_block7", {bus.gnt1, bus.gnt2}, 0);
    tick();
    chk("cd_block8", {bus.gnt1, bus.gnt2}, 0);
    push(0, PC, 0, 1, 0);
    press_tick(1, 0);
    serve(0, 0, 0, PB, 0, 0);

    // Reset in the middle of a flight.
    tick();
    tick();
    press_tick(1, 0);
    chk("pre_rst_gnt", bus.gnt1, 1);
    tick();
    tick();
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_row", bus.shot_row, 0);
    chk("mid_rst_scores",
        {bus.score1, bus.score2}, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_gnt_hit",
        {bus.gnt1, bus.gnt2,
         bus.hit1, bus.hit2}, 0);

    // Collision: P1 first, then P2.
    setpos(PA, PB);
    push(0, PA, 0, 0, 0);
    press_tick(1, 1);
    serve(0, 0, 0, 0, 0, 0);
    push(1, PB, 1, 0, 1);
`ifdef SHOT_QUEUE_EN
    serve(5, 3, PB, 0, 0, 0);
`else
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("loser_dropped",
          {bus.gnt1, bus.gnt2}, 0);
    end
    press_tick(1, 1);
    serve(0, 0, PB, 0, 0, 0);
`endif

    // P2 presses during P1's flight.
    tick();
    tick();
    push(0, PB, 1, 1, 1);
    press_tick(1, 0);
    serve(0, 0, 0, 0, 0, 1);
    push(1, PB, 1, 1, 2);
`ifdef SHOT_QUEUE_EN
    serve(5, 3, 0, 0, 0, 0);
`else
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fly_press_dropped",
          {bus.gnt1, bus.gnt2}, 0);
    end
    press_tick(0, 1);
    serve(0, 0, 0, 0, 0, 0);
`endif

    // Third P2 hit ends the game.
    tick();
    tick();
    push(1, PB, 1, 1, 3);
    press_tick(0, 1);
    serve(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      press_tick(1, 1);
      chk("over_gnt", {bus.gnt1, bus.gnt2}, 0);
      chk("over_busy", bus.busy, 0);
      chk("over_hit", {bus.hit1, bus.hit2}, 0);
      chk("over_done", bus.done, 1);
      chk("over_winner", bus.winner, 1);
      chk("over_scores",
          {bus.score1, bus.score2}, 4'b0111);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("final_rst_done", bus.done, 0);
    chk("final_rst_scores",
        {bus.score1, bus.score2}, 0);

    $display("%0d/%0d checks passed",
             npass, ntotal);
    $finish;
  end

endmodule
